// File: rtl/hub75_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_scan_controller
//  Description : Scans a frame buffer out to a chain of HUB75 LED panels.
//                Pixels are fetched through the read-only port B of a
//                dual-port memory (one-cycle read latency). Pixels are shown
//                with binary-coded modulation over BPC bit planes and a
//                1/(HEIGHT/2) row-pair scan.
//
//                For each row pair and each plane, the sequence is:
//                  1. For every column, fetch the upper and lower pixel and
//                     shift one bit of each colour into the panel.
//                  2. Blank the outputs, latch the shifted plane and select
//                     the row pair.
//                  3. Enable the outputs for BASE_DISPLAY<<plane cycles.
//
//  Ports       : clk         system clock, rising edge
//                rst         asynchronous reset, active low
//                en          start / continue scanning. Sampled in IDLE and
//                            at the end of a frame.
//                mem_addr    port B address, row*COLS + col
//                mem_re      port B read enable
//                mem_dat     port B read data, valid the cycle after mem_re
//                r0 g0 b0    upper-half colour bits
//                r1 g1 b1    lower-half colour bits
//                panel_clk   shift clock; the panel samples on the rising edge
//                panel_lat   latch strobe, active high
//                panel_oe_n  output enable, active low
//                row_addr    row pair select (A..E)
//                frame_done  one-cycle pulse at the end of every full frame
//
//  Configuration: HEIGHT must be even and at least 4.
//                 CHAINED*WIDTH*HEIGHT must not exceed 16384.
//                 BPP must equal 3*BPC.
//                 BASE_DISPLAY must be at least 1.
//  Revision    : 1.0  initial release
// ============================================================================
module hub75_scan_controller #(
   parameter int WIDTH        = 96,
   parameter int HEIGHT       = 48,
   parameter int BPP          = 12,
   parameter int BPC          = 4,
   parameter int CHAINED      = 1,
   parameter int BASE_DISPLAY = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   output logic [13:0]                   mem_addr,
   output logic                          mem_re,
   input  logic [BPP-1:0]                mem_dat,
   output logic                          r0,
   output logic                          g0,
   output logic                          b0,
   output logic                          r1,
   output logic                          g1,
   output logic                          b1,
   output logic                          panel_clk,
   output logic                          panel_lat,
   output logic                          panel_oe_n,
   output logic [$clog2(HEIGHT/2)-1:0]   row_addr,
   output logic                          frame_done
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int c_COLS   = CHAINED * WIDTH;
   localparam int c_ROWS   = HEIGHT / 2;
   localparam int c_COL_W  = (c_COLS > 1) ? $clog2(c_COLS) : 1;
   localparam int c_ROW_W  = $clog2(c_ROWS);
   localparam int c_PL_W   = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int c_DISP_W = $clog2((BASE_DISPLAY << (BPC - 1)) + 1);

   localparam logic [c_COL_W-1:0]  c_COL_LAST   = c_COL_W'(c_COLS - 1);
   localparam logic [c_ROW_W-1:0]  c_ROW_LAST   = c_ROW_W'(c_ROWS - 1);
   localparam logic [c_PL_W-1:0]   c_PLANE_LAST = c_PL_W'(BPC - 1);
   localparam logic [c_DISP_W-1:0] c_DISP_ONE   = c_DISP_W'(1);
   localparam logic [c_DISP_W-1:0] c_DISP_BASE  = c_DISP_W'(BASE_DISPLAY);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_RD_TOP  = 4'd1;
   localparam logic [3:0] S_RD_BOT  = 4'd2;
   localparam logic [3:0] S_CLK_LO  = 4'd3;
   localparam logic [3:0] S_CLK_HI  = 4'd4;
   localparam logic [3:0] S_BLANK   = 4'd5;
   localparam logic [3:0] S_LATCH   = 4'd6;
   localparam logic [3:0] S_DISPLAY = 4'd7;
   localparam logic [3:0] S_NEXT    = 4'd8;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [3:0]          r_state;
   logic [c_COL_W-1:0]  r_col;
   logic [c_ROW_W-1:0]  r_row;
   logic [c_PL_W-1:0]   r_plane;
   logic [c_DISP_W-1:0] r_disp;
   logic [BPP-1:0]      r_top_q;
   logic [2:0]          r_top_bits;
   logic [2:0]          r_bot_bits;
   logic [c_ROW_W-1:0]  r_row_addr;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [BPC-1:0]      w_top_r;
   logic [BPC-1:0]      w_top_g;
   logic [BPC-1:0]      w_top_b;
   logic [BPC-1:0]      w_bot_r;
   logic [BPC-1:0]      w_bot_g;
   logic [BPC-1:0]      w_bot_b;
   logic [2:0]          w_top_bits;
   logic [2:0]          w_bot_bits;
   logic [13:0]         w_addr_upper;
   logic [13:0]         w_addr_lower;
   logic                w_last_col;
   logic                w_last_row;
   logic                w_last_plane;
   logic [c_DISP_W-1:0] w_disp_load;

   // Split each pixel into its colour channels. Packing is {R, G, B}.
   assign w_top_r = r_top_q[3*BPC-1:2*BPC];
   assign w_top_g = r_top_q[2*BPC-1:BPC];
   assign w_top_b = r_top_q[BPC-1:0];
   assign w_bot_r = mem_dat[3*BPC-1:2*BPC];
   assign w_bot_g = mem_dat[2*BPC-1:BPC];
   assign w_bot_b = mem_dat[BPC-1:0];

   // Take the bit of the current plane from each channel.
   assign w_top_bits = {w_top_r[r_plane], w_top_g[r_plane], w_top_b[r_plane]};
   assign w_bot_bits = {w_bot_r[r_plane], w_bot_g[r_plane], w_bot_b[r_plane]};

   // The upper half of the panel is rows 0..ROWS-1.
   // The lower half is rows ROWS..HEIGHT-1.
   assign w_addr_upper = 14'(r_row) * 14'(c_COLS) + 14'(r_col);
   assign w_addr_lower = (14'(r_row) + 14'(c_ROWS)) * 14'(c_COLS) + 14'(r_col);

   assign w_last_col   = (r_col   == c_COL_LAST);
   assign w_last_row   = (r_row   == c_ROW_LAST);
   assign w_last_plane = (r_plane == c_PLANE_LAST);
   assign w_disp_load  = c_DISP_BASE << r_plane;

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_col      <= '0;
         r_row      <= '0;
         r_plane    <= '0;
         r_disp     <= '0;
         r_top_q    <= '0;
         r_top_bits <= '0;
         r_bot_bits <= '0;
         r_row_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_state <= S_RD_TOP;
               end
            end

            S_RD_TOP: begin
               r_state <= S_RD_BOT;
            end

            // The upper pixel requested in RD_TOP is on mem_dat now.
            S_RD_BOT: begin
               r_top_q <= mem_dat;
               r_state <= S_CLK_LO;
            end

            // The lower pixel is on mem_dat now. Capture both colour
            // triplets so they hold through the rising panel_clk.
            S_CLK_LO: begin
               r_top_bits <= w_top_bits;
               r_bot_bits <= w_bot_bits;
               r_state    <= S_CLK_HI;
            end

            S_CLK_HI: begin
               if (w_last_col) begin
                  r_col   <= '0;
                  r_state <= S_BLANK;
               end else begin
                  r_col   <= r_col + 1'b1;
                  r_state <= S_RD_TOP;
               end
            end

            // Move the row select while the outputs are already dark.
            // row_addr is then stable for the whole LATCH cycle and for
            // the following display window.
            S_BLANK: begin
               r_row_addr <= r_row;
               r_state    <= S_LATCH;
            end

            S_LATCH: begin
               r_disp  <= w_disp_load;
               r_state <= S_DISPLAY;
            end

            // r_disp counts down from N to 1, so the outputs are enabled
            // for exactly N cycles.
            S_DISPLAY: begin
               if (r_disp <= c_DISP_ONE) begin
                  r_disp  <= '0;
                  r_state <= S_NEXT;
               end else begin
                  r_disp <= r_disp - 1'b1;
               end
            end

            S_NEXT: begin
               if (!w_last_plane) begin
                  r_plane <= r_plane + 1'b1;
                  r_state <= S_RD_TOP;
               end else begin
                  r_plane <= '0;
                  if (!w_last_row) begin
                     r_row   <= r_row + 1'b1;
                     r_state <= S_RD_TOP;
                  end else begin
                     // The frame is complete. en decides whether another
                     // frame starts, so a frame is never cut short.
                     r_row   <= '0;
                     r_state <= en ? S_RD_TOP : S_IDLE;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // These are decoded from the state register. An asynchronous reset
   // therefore blanks the panel and releases the memory port immediately.
   // ------------------------------------------------------------------------
   always_comb begin
      mem_addr = '0;
      mem_re   = 1'b0;
      case (r_state)
         S_RD_TOP: begin
            mem_addr = w_addr_upper;
            mem_re   = 1'b1;
         end
         S_RD_BOT: begin
            mem_addr = w_addr_lower;
            mem_re   = 1'b1;
         end
         default: begin
            mem_addr = '0;
            mem_re   = 1'b0;
         end
      endcase
   end

   // In CLK_LO the colour bits come straight from the fetched pixels.
   // The captured copy then keeps them unchanged across the rising edge.
   always_comb begin
      {r0, g0, b0} = r_top_bits;
      {r1, g1, b1} = r_bot_bits;
      if (r_state == S_CLK_LO) begin
         {r0, g0, b0} = w_top_bits;
         {r1, g1, b1} = w_bot_bits;
      end
   end

   assign panel_clk  = (r_state == S_CLK_HI);
   assign panel_lat  = (r_state == S_LATCH);
   assign panel_oe_n = (r_state != S_DISPLAY);
   assign row_addr   = r_row_addr;
   assign frame_done = (r_state == S_NEXT) && w_last_plane && w_last_row;

endmodule
`default_nettype wire
